// File: rtl/vm_tlb_cache_if.sv
// CPU-side request/response bundle for the translating cache front end.
// The CPU drives the request fields; the cache returns registered results.
interface vm_tlb_cache_if;
    logic        en;
    logic        read_write;
    logic        clear_refer;
    logic [11:0] virtual_address;
    logic [31:0] write_data;
    logic [9:0]  physical_address;
    logic [31:0] read_data;
    logic        tlb_hit;
    logic        cache_hit;

    modport master (
        output en, read_write, clear_refer, virtual_address, write_data,
        input  physical_address, read_data, tlb_hit, cache_hit
    );
    modport slave (
        input  en, read_write, clear_refer, virtual_address, write_data,
        output physical_address, read_data, tlb_hit, cache_hit
    );
endinterface

// File: rtl/vm_tlb_cache.sv
// Single-cycle VA->PA translation (clock-replacement TLB over a fixed page table)
// feeding a 2-way write-back, write-allocate cache in front of 1 KB of memory.
module vm_tlb_cache #(
    parameter int TLB_ENTRIES = 8
) (
    input logic           clk,
    input logic           rst_n,
    vm_tlb_cache_if.slave bus
);
    localparam int IW = $clog2(TLB_ENTRIES);
    typedef logic [IW-1:0] tidx_t;

    logic [TLB_ENTRIES-1:0]      tlb_vld_q, tlb_vld_d, tlb_ref_q, tlb_ref_d;
    logic [TLB_ENTRIES-1:0][7:0] tlb_vpn_q, tlb_vpn_d;
    logic [TLB_ENTRIES-1:0][5:0] tlb_ppn_q, tlb_ppn_d;
    tidx_t                       ptr_q, ptr_d;

    logic [3:0][1:0]             c_vld_q, c_vld_d, c_dirty_q, c_dirty_d;
    logic [3:0][1:0][3:0]        c_tag_q, c_tag_d;
    logic [3:0]                  lru_q, lru_d;
    logic [3:0][1:0][3:0][31:0]  cdata_q;
    logic [31:0]                 mem_q [256];

    logic [9:0]  pa_q, pa_d;
    logic [31:0] rd_q, rd_d;
    logic        th_q, th_d, ch_q, ch_d;

    logic [7:0]             vpn;
    logic [TLB_ENTRIES-1:0] ref_eff, clr_mask;
    logic                   t_hit, inv_found, rz_found, c_hit, hway, way, line_we, wb_en;
    tidx_t                  hit_idx, vic, idx;
    logic [5:0]             ppn;
    logic [9:0]             pa;
    logic [1:0]             set, word;
    logic [3:0]             tag;
    logic [3:0][31:0]       line;

    always_comb begin
        tlb_vld_d = tlb_vld_q;
        tlb_vpn_d = tlb_vpn_q;
        tlb_ppn_d = tlb_ppn_q;
        ptr_d     = ptr_q;
        c_vld_d   = c_vld_q;
        c_dirty_d = c_dirty_q;
        c_tag_d   = c_tag_q;
        lru_d     = lru_q;
        pa_d      = pa_q;
        rd_d      = rd_q;
        th_d      = th_q;
        ch_d      = ch_q;
        line_we   = 1'b0;
        wb_en     = 1'b0;
        vpn       = bus.virtual_address[11:4];
        ref_eff   = bus.clear_refer ? '0 : tlb_ref_q;
        tlb_ref_d = ref_eff;

        t_hit   = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_vld_q[i] && tlb_vpn_q[i] == vpn) begin
                t_hit   = 1'b1;
                hit_idx = tidx_t'(i);
            end
        end

        // Victim: lowest invalid entry, else clock sweep giving referenced entries a second chance.
        inv_found = 1'b0;
        rz_found  = 1'b0;
        vic       = ptr_q;
        idx       = ptr_q;
        clr_mask  = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (!inv_found && !tlb_vld_q[i]) begin
                inv_found = 1'b1;
                vic       = tidx_t'(i);
            end
        end
        if (!inv_found) begin
            for (int k = 0; k < TLB_ENTRIES; k++) begin
                idx = ptr_q + tidx_t'(k);
                if (!rz_found) begin
                    if (!ref_eff[idx]) begin
                        rz_found = 1'b1;
                        vic      = idx;
                    end else begin
                        clr_mask[idx] = 1'b1;
                    end
                end
            end
            if (!rz_found) clr_mask = '0;
        end

        ppn  = t_hit ? tlb_ppn_q[hit_idx] : vpn[5:0];
        pa   = {ppn, bus.virtual_address[3:0]};
        set  = pa[5:4];
        tag  = pa[9:6];
        word = pa[3:2];

        c_hit = 1'b0;
        hway  = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (c_vld_q[set][w] && c_tag_q[set][w] == tag) begin
                c_hit = 1'b1;
                hway  = 1'(w);
            end
        end
        way = c_hit ? hway : (!c_vld_q[set][0] ? 1'b0 : (!c_vld_q[set][1] ? 1'b1 : lru_q[set]));

        for (int w = 0; w < 4; w++)
            line[w] = c_hit ? cdata_q[set][way][w] : mem_q[{tag, set, 2'(w)}];
        if (bus.read_write) line[word] = bus.write_data;

        if (bus.en) begin
            if (t_hit) begin
                tlb_ref_d[hit_idx] = 1'b1;
            end else begin
                tlb_ref_d      = ref_eff & ~clr_mask;
                tlb_vld_d[vic] = 1'b1;
                tlb_ref_d[vic] = 1'b1;
                tlb_vpn_d[vic] = vpn;
                tlb_ppn_d[vic] = vpn[5:0];
                ptr_d          = vic + tidx_t'(1);
            end
            line_we            = 1'b1;
            wb_en              = !c_hit && c_vld_q[set][way] && c_dirty_q[set][way];
            c_vld_d[set][way]  = 1'b1;
            c_tag_d[set][way]  = tag;
            c_dirty_d[set][way] = c_hit ? (c_dirty_q[set][way] | bus.read_write) : bus.read_write;
            lru_d[set]         = ~way;
            pa_d               = pa;
            rd_d               = line[word];
            th_d               = t_hit;
            ch_d               = c_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlb_vld_q <= '0;
            tlb_ref_q <= '0;
            tlb_vpn_q <= '0;
            tlb_ppn_q <= '0;
            ptr_q     <= '0;
            c_vld_q   <= '0;
            c_dirty_q <= '0;
            c_tag_q   <= '0;
            lru_q     <= '0;
            pa_q      <= '0;
            rd_q      <= '0;
            th_q      <= 1'b0;
            ch_q      <= 1'b0;
        end else begin
            tlb_vld_q <= tlb_vld_d;
            tlb_ref_q <= tlb_ref_d;
            tlb_vpn_q <= tlb_vpn_d;
            tlb_ppn_q <= tlb_ppn_d;
            ptr_q     <= ptr_d;
            c_vld_q   <= c_vld_d;
            c_dirty_q <= c_dirty_d;
            c_tag_q   <= c_tag_d;
            lru_q     <= lru_d;
            pa_q      <= pa_d;
            rd_q      <= rd_d;
            th_q      <= th_d;
            ch_q      <= ch_d;
        end
    end

    // Storage arrays carry no reset; cache contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (wb_en)
            for (int w = 0; w < 4; w++)
                mem_q[{c_tag_q[set][way], set, 2'(w)}] <= cdata_q[set][way][w];
        if (line_we) cdata_q[set][way] <= line;
    end

    assign bus.physical_address = pa_q;
    assign bus.read_data        = rd_q;
    assign bus.tlb_hit          = th_q;
    assign bus.cache_hit        = ch_q;
endmodule

// File: tb/tb_vm_tlb_cache.sv
// Directed + randomized bench for vm_tlb_cache against a behavioural model
// (coherent memory view, per-set MRU lists, clock-algorithm TLB).
module tb_vm_tlb_cache;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vm_tlb_cache_if bus ();
    vm_tlb_cache #(.TLB_ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    // model state
    bit          mv [N];
    bit          mr [N];
    int          mvpn [N];
    int          mptr;
    logic [31:0] coh [256];
    logic [31:0] mainm [256];
    bit          dirtyb [64];
    int          mru [4][$];
    logic [9:0]  exp_pa;
    logic [31:0] exp_rd;
    logic        exp_th, exp_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_pa"}, {22'b0, bus.physical_address}, {22'b0, exp_pa});
        chk({tag, "_rd"}, bus.read_data, exp_rd);
        chk({tag, "_tlbhit"}, {31'b0, bus.tlb_hit}, {31'b0, exp_th});
        chk({tag, "_cachehit"}, {31'b0, bus.cache_hit}, {31'b0, exp_ch});
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
        mptr = 0;
        // dirty data still in the cache is lost; memory keeps its last written-back value
        for (int b = 0; b < 64; b++) begin
            if (dirtyb[b]) for (int w = 0; w < 4; w++) coh[b*4+w] = mainm[b*4+w];
            dirtyb[b] = 0;
        end
        for (int s = 0; s < 4; s++) mru[s].delete();
        exp_pa = '0; exp_rd = '0; exp_th = 0; exp_ch = 0;
    endfunction

    function automatic bit m_tlb(input int vpn);
        int vic = -1;
        for (int i = 0; i < N; i++)
            if (mv[i] && mvpn[i] == vpn) begin mr[i] = 1; return 1'b1; end
        for (int i = 0; i < N; i++)
            if (!mv[i]) begin vic = i; break; end
        if (vic < 0) begin
            for (int k = 0; k < N; k++) begin
                if (!mr[(mptr + k) % N]) begin
                    vic = (mptr + k) % N;
                    for (int j = 0; j < k; j++) mr[(mptr + j) % N] = 0;
                    break;
                end
            end
            if (vic < 0) vic = mptr;
        end
        mv[vic] = 1; mr[vic] = 1; mvpn[vic] = vpn;
        mptr = (vic + 1) % N;
        return 1'b0;
    endfunction

    function automatic void m_access(input bit en, input bit rw, input bit clr,
                                     input logic [11:0] va, input logic [31:0] wd);
        int b, s, ev, pos;
        if (clr) for (int i = 0; i < N; i++) mr[i] = 0;
        if (!en) return;
        exp_th = m_tlb(int'(va[11:4]));
        exp_pa = va[9:0];               // page table maps PPN = VPN[5:0]
        b = int'(va[9:4]);
        s = b % 4;
        pos = -1;
        foreach (mru[s][i]) if (mru[s][i] == b) pos = i;
        exp_ch = (pos >= 0);
        if (pos >= 0) mru[s].delete(pos);
        else if (mru[s].size() == 2) begin
            ev = mru[s].pop_back();
            if (dirtyb[ev]) begin
                for (int w = 0; w < 4; w++) mainm[ev*4+w] = coh[ev*4+w];
                dirtyb[ev] = 0;
            end
        end
        mru[s].push_front(b);
        if (rw) begin coh[va[9:2]] = wd; dirtyb[b] = 1; end
        exp_rd = coh[va[9:2]];
    endfunction

    task automatic step(input bit en, input bit rw, input bit clr,
                        input logic [11:0] va, input logic [31:0] wd);
        @(negedge clk);
        bus.en = en; bus.read_write = rw; bus.clear_refer = clr;
        bus.virtual_address = va; bus.write_data = wd;
        @(posedge clk);
        m_access(en, rw, clr, va, wd);
        #1;
        check_outs(en ? "acc" : "idle");
        bus.en = 1'b0; bus.clear_refer = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit en, rw, clr;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin coh[i] = '0; mainm[i] = '0; end
        for (int b = 0; b < 64; b++) dirtyb[b] = 0;
        bus.en = 0; bus.read_write = 0; bus.clear_refer = 0;
        bus.virtual_address = '0; bus.write_data = '0;
        #2;
        apply_reset();

        // write-back / LRU walk
        step(1, 0, 0, 12'h000, 0);
        chk("plan_first_tlbhit", {31'b0, bus.tlb_hit}, 32'd0);
        chk("plan_first_rd", bus.read_data, 32'h0);
        step(1, 1, 0, 12'h000, 32'h0000_00FF);
        chk("plan_wr_cachehit", {31'b0, bus.cache_hit}, 32'd1);
        step(1, 0, 0, 12'h000, 0);
        chk("plan_rd_ff", bus.read_data, 32'h0000_00FF);
        chk("mem0_before_wb", dut.mem_q[0], 32'h0);
        step(1, 0, 0, 12'h200, 0);
        step(1, 0, 0, 12'h000, 0);
        step(1, 0, 0, 12'h300, 0);
        step(1, 0, 0, 12'h200, 0);
        chk("mem0_after_wb", dut.mem_q[0], 32'h0000_00FF);
        chk("mem0_model", dut.mem_q[0], mainm[0]);
        step(1, 0, 0, 12'h000, 0);
        chk("plan_refill_cachehit", {31'b0, bus.cache_hit}, 32'd0);
        chk("plan_refill_rd", bus.read_data, 32'h0000_00FF);

        // TLB clock replacement
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0, 12'(i << 4), 0);
            chk("tlb_fill_miss", {31'b0, bus.tlb_hit}, 32'd0);
        end
        step(1, 0, 0, 12'h000, 0);
        chk("tlb_vpn0_evicted", {31'b0, bus.tlb_hit}, 32'd0);
        step(0, 0, 1, 12'h000, 0);
        step(1, 0, 0, 12'h020, 0);
        chk("tlb_vpn2_hit", {31'b0, bus.tlb_hit}, 32'd1);
        step(1, 0, 0, 12'h100, 0);
        step(1, 1, 0, 12'h024, 32'hDEAD_BEEF);
        chk("tlb_vpn2_resident", {31'b0, bus.tlb_hit}, 32'd1);

        // reset in the middle of activity
        step(1, 0, 0, 12'h030, 0);
        apply_reset();
        step(1, 0, 0, 12'h024, 0);
        chk("post_reset_tlbhit", {31'b0, bus.tlb_hit}, 32'd0);
        chk("post_reset_cachehit", {31'b0, bus.cache_hit}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom % 8) != 0;
            rw  = $urandom % 2;
            clr = ($urandom % 10) == 0;
            v   = ($urandom % 4 == 0) ? 8'($urandom % 256) : 8'($urandom_range(0, 23));
            step(en, rw, clr, {v, 4'($urandom % 16)}, $urandom);
            if (i == 200) apply_reset();
        end
        for (int w = 0; w < 16; w++) chk("mem_final", dut.mem_q[w], mainm[w]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
